// File: rtl/regfile_dump_uart_if.sv
// Register-dump port bundle: register-file read port plus UART/status lines.
// master = dump engine, slave = register bank / board top.
interface regfile_dump_uart_if;
   logic        start;
   logic [4:0]  ra;
   logic [31:0] rd;
   logic        tx;
   logic        busy;
   logic        done;

   modport master (
      input  start,
      input  rd,
      output ra,
      output tx,
      output busy,
      output done
   );

   modport slave (
      output start,
      output rd,
      input  ra,
      input  tx,
      input  busy,
      input  done
   );
endinterface

// File: rtl/regfile_dump_uart.sv
// Register bank dumper: walks every register through a read port and
// streams index byte + 4 data bytes (MSB first) per register over UART 8N1.
module regfile_dump_uart #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NUM_REGS     = 32
) (
   input logic                 clk,
   input logic                 rst,
   regfile_dump_uart_if.master bus
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [4:0] LAST_RA = 5'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [4:0]    ra_q, ra_d;
   logic [2:0]    byte_idx_q, byte_idx_d;
   logic [2:0]    bit_q, bit_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [31:0]   shadow_q, shadow_d;
   logic [7:0]    txbyte_q, txbyte_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          baud_end;

   assign baud_end = (baud_q == BAUD_MAX);

   // Next state, datapath updates, and registered-output values.
   always_comb begin
      state_d    = state_q;
      ra_d       = ra_q;
      byte_idx_d = byte_idx_q;
      bit_d      = bit_q;
      baud_d     = baud_q;
      shadow_d   = shadow_q;
      txbyte_d   = txbyte_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_FETCH;
               ra_d       = '0;
               byte_idx_d = '0;
               baud_d     = '0;
            end
         end
         S_FETCH: begin
            shadow_d = bus.rd;
            txbyte_d = {3'b000, ra_q};
            state_d  = S_START;
            baud_d   = '0;
         end
         S_START: begin
            if (baud_end) begin
               state_d = S_DATA;
               bit_d   = '0;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (byte_idx_q < 3'd4) begin
                  // Data bytes go out MSB first after the index byte.
                  unique case (byte_idx_q)
                     3'd0:    txbyte_d = shadow_q[31:24];
                     3'd1:    txbyte_d = shadow_q[23:16];
                     3'd2:    txbyte_d = shadow_q[15:8];
                     default: txbyte_d = shadow_q[7:0];
                  endcase
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = S_START;
               end else if (ra_q < LAST_RA) begin
                  ra_d       = ra_q + 5'd1;
                  byte_idx_d = '0;
                  state_d    = S_FETCH;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DONE: begin
            ra_d    = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered, so derive them from the upcoming state.
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
      tx_d   = 1'b1;
      if (state_d == S_START) begin
         tx_d = 1'b0;
      end else if (state_d == S_DATA) begin
         tx_d = txbyte_d[bit_d];
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         ra_q       <= '0;
         byte_idx_q <= '0;
         bit_q      <= '0;
         baud_q     <= '0;
         shadow_q   <= '0;
         txbyte_q   <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ra_q       <= ra_d;
         byte_idx_q <= byte_idx_d;
         bit_q      <= bit_d;
         baud_q     <= baud_d;
         shadow_q   <= shadow_d;
         txbyte_q   <= txbyte_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.ra   = ra_q;
   assign bus.tx   = tx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_regfile_dump_uart.sv
// Directed bench for regfile_dump_uart: two instances (32 and 4 registers)
// at 4 clocks per bit, with a cycle-based UART decoder on the 32-reg line.
module tb_regfile_dump_uart;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regfile_dump_uart_if busA ();
   regfile_dump_uart_if busB ();

   logic [31:0] regsA [32];
   logic [31:0] regsB [32];
   logic [31:0] expA  [32];

   assign busA.rd = regsA[busA.ra];
   assign busB.rd = regsB[busB.ra];

   regfile_dump_uart #(
      .CLKS_PER_BIT(CPB),
      .NUM_REGS    (32)
   ) dutA (
      .clk(clk),
      .rst(rst),
      .bus(busA)
   );

   regfile_dump_uart #(
      .CLKS_PER_BIT(CPB),
      .NUM_REGS    (4)
   ) dutB (
      .clk(clk),
      .rst(rst),
      .bus(busB)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // UART receiver on busA.tx, sampling mid-bit.
   logic [7:0] rxq [$];
   logic       dec_clr = 1'b0;
   logic       tx_prev = 1'b1;
   logic       dact    = 1'b0;
   int         dcnt    = 0;
   logic [7:0] dsh     = '0;

   always @(posedge clk) begin
      tx_prev <= busA.tx;
      if (dec_clr) begin
         dact <= 1'b0;
      end else if (!dact) begin
         if (tx_prev && !busA.tx) begin
            dact <= 1'b1;
            dcnt <= 1;
         end
      end else begin
         dcnt <= dcnt + 1;
         if ((dcnt + 1) % 4 == 2) begin
            if ((dcnt + 1) / 4 >= 1 && (dcnt + 1) / 4 <= 8)
               dsh[3'((dcnt + 1) / 4 - 1)] <= busA.tx;
            if ((dcnt + 1) / 4 == 9) begin
               rxq.push_back(dsh);
               dact <= 1'b0;
            end
         end
      end
   end

   function automatic logic [7:0] exp_byte(input int idx);
      int n;
      logic [31:0] w;
      n = idx / 5;
      w = expA[n];
      case (idx % 5)
         0:       return 8'(n);
         1:       return w[31:24];
         2:       return w[23:16];
         3:       return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   function automatic int stream_errs();
      int e;
      e = 0;
      if (rxq.size() != 160) return 999;
      for (int i = 0; i < 160; i++)
         if (rxq[i] !== exp_byte(i)) e++;
      return e;
   endfunction

   task automatic init_regs();
      for (int i = 0; i < 32; i++) begin
         regsA[i] = 32'hA500_0000 | 32'(i);
         expA[i]  = 32'hA500_0000 | 32'(i);
         regsB[i] = 32'hA500_0000 | 32'(i);
      end
      regsB[3] = 32'h1234_5678;
   endtask

   // Pulses start on busA and follows the dump for a fixed cycle budget.
   task automatic run_dump_a(
      input  int   restart_at,
      input  bit   live,
      output int   busy_cnt,
      output int   done_cnt,
      output logic tx0,
      output logic tx1
   );
      rxq.delete();
      busy_cnt = 0;
      done_cnt = 0;
      tx0 = 1'bx;
      tx1 = 1'bx;
      @(posedge clk); #1;
      busA.start = 1'b1;
      @(posedge clk); #1;
      busA.start = 1'b0;
      for (int i = 0; i < 6500; i++) begin
         if (i == 0) tx0 = busA.tx;
         if (i == 1) tx1 = busA.tx;
         if (busA.busy) busy_cnt++;
         if (busA.done) done_cnt++;
         busA.start = (i == restart_at);
         if (live && i == 300) regsA[1] = 32'h0;
         if (live && i == 450) regsA[10] = 32'hDEAD_BEEF;
         @(posedge clk); #1;
      end
      busA.start = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b0;
      busA.start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_assert++;
      if (busA.busy !== 1'b0) begin
         $display("FAIL rst_over_start busy=%b want 0", busA.busy);
         n_fail++;
      end
      busA.start = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      n_assert++;
      if ({busA.tx, busA.busy, busA.done, busA.ra} !== {3'b100, 5'd0}) begin
         $display("FAIL reset_state tx/busy/done/ra=%b%b%b/%0d want 100/0",
                  busA.tx, busA.busy, busA.done, busA.ra);
         n_fail++;
      end
      n_assert++;
      if ({busB.tx, busB.busy, busB.done} !== 3'b100) begin
         $display("FAIL reset_state_b tx/busy/done=%b%b%b want 100",
                  busB.tx, busB.busy, busB.done);
         n_fail++;
      end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (busA.tx !== 1'b1 || busA.busy !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      n_assert++;
      if (bad != 0) begin
         $display("FAIL idle_quiet bad_cycles=%0d want 0", bad);
         n_fail++;
      end
   endtask

   task automatic test_full_dump();
      int bc, dc;
      logic t0, t1;
      run_dump_a(-1, 1'b0, bc, dc, t0, t1);
      n_assert++;
      if ({t0, t1} !== 2'b10) begin
         $display("FAIL start_latency tx=%b,%b want 1,0", t0, t1);
         n_fail++;
      end
      n_assert++;
      if (rxq.size() != 160) begin
         $display("FAIL byte_count got %0d want 160", rxq.size());
         n_fail++;
      end
      n_assert++;
      if ({rxq[25], rxq[26], rxq[27], rxq[28], rxq[29]} !== 40'h05A5000005) begin
         $display("FAIL reg5_bytes got %h %h %h %h %h want 05 a5 00 00 05",
                  rxq[25], rxq[26], rxq[27], rxq[28], rxq[29]);
         n_fail++;
      end
      n_assert++;
      if (stream_errs() != 0) begin
         $display("FAIL full_stream errors=%0d want 0", stream_errs());
         n_fail++;
      end
      n_assert++;
      if (bc != 6432) begin
         $display("FAIL busy_cycles got %0d want 6432", bc);
         n_fail++;
      end
      n_assert++;
      if (dc != 1) begin
         $display("FAIL done_pulses got %0d want 1", dc);
         n_fail++;
      end
   endtask

   task automatic test_bit_order();
      logic wtx [810];
      logic wdn [810];
      logic wbz [810];
      logic [9:0] pat;
      logic [39:0] got;
      logic [7:0] b;
      int dcnt_b, bad, s;
      pat = {1'b1, 8'h12, 1'b0};
      @(posedge clk); #1;
      busB.start = 1'b1;
      @(posedge clk); #1;
      busB.start = 1'b0;
      for (int i = 0; i < 810; i++) begin
         wtx[i] = busB.tx;
         wdn[i] = busB.done;
         wbz[i] = busB.busy;
         @(posedge clk); #1;
      end
      n_assert++;
      if ({wtx[0], wtx[1]} !== 2'b10) begin
         $display("FAIL b_latency tx=%b,%b want 1,0", wtx[0], wtx[1]);
         n_fail++;
      end
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int c = 0; c < CPB; c++)
            if (wtx[644 + CPB * k + c] !== pat[k]) bad++;
         n_assert++;
         if (bad != 0) begin
            $display("FAIL wire_bit%0d bad_cycles=%0d want level %b",
                     k, bad, pat[k]);
            n_fail++;
         end
      end
      got = '0;
      for (int k = 0; k < 5; k++) begin
         s = 604 + 40 * k;
         for (int j = 0; j < 8; j++)
            b[j] = wtx[s + CPB * (j + 1) + 2];
         got = {got[31:0], b};
      end
      n_assert++;
      if (got !== 40'h0312345678) begin
         $display("FAIL reg3_bytes got %h want 0312345678", got);
         n_fail++;
      end
      dcnt_b = 0;
      for (int i = 0; i < 810; i++)
         if (wdn[i] === 1'b1) dcnt_b++;
      n_assert++;
      if (wdn[804] !== 1'b1 || dcnt_b != 1) begin
         $display("FAIL b_done at804=%b count=%0d want 1/1", wdn[804], dcnt_b);
         n_fail++;
      end
      n_assert++;
      if ({wbz[803], wbz[804]} !== 2'b10) begin
         $display("FAIL b_busy_end got %b%b want 10", wbz[803], wbz[804]);
         n_fail++;
      end
   endtask

   task automatic test_start_busy();
      int bc, dc;
      logic t0, t1;
      run_dump_a(500, 1'b0, bc, dc, t0, t1);
      n_assert++;
      if (bc != 6432 || dc != 1) begin
         $display("FAIL start_busy busy=%0d done=%0d want 6432/1", bc, dc);
         n_fail++;
      end
      n_assert++;
      if (stream_errs() != 0) begin
         $display("FAIL start_busy_stream errors=%0d want 0", stream_errs());
         n_fail++;
      end
   endtask

   task automatic test_live_update();
      int bc, dc;
      logic t0, t1;
      expA[10] = 32'hDEAD_BEEF;
      run_dump_a(-1, 1'b1, bc, dc, t0, t1);
      n_assert++;
      if ({rxq[50], rxq[51], rxq[52], rxq[53], rxq[54]} !== 40'h0ADEADBEEF) begin
         $display("FAIL live_reg10 got %h %h %h %h %h want 0a de ad be ef",
                  rxq[50], rxq[51], rxq[52], rxq[53], rxq[54]);
         n_fail++;
      end
      n_assert++;
      if ({rxq[5], rxq[6], rxq[7], rxq[8], rxq[9]} !== 40'h01A5000001) begin
         $display("FAIL live_reg1 got %h %h %h %h %h want 01 a5 00 00 01",
                  rxq[5], rxq[6], rxq[7], rxq[8], rxq[9]);
         n_fail++;
      end
      n_assert++;
      if (stream_errs() != 0) begin
         $display("FAIL live_stream errors=%0d want 0", stream_errs());
         n_fail++;
      end
      init_regs();
   endtask

   task automatic test_reset_midframe();
      int bc, dc, dn;
      logic t0, t1;
      logic [4:0] ra7;
      ra7 = '0;
      @(posedge clk); #1;
      busA.start = 1'b1;
      @(posedge clk); #1;
      busA.start = 1'b0;
      for (int i = 0; i < 1460; i++) begin
         if (i == 1450) ra7 = busA.ra;
         @(posedge clk); #1;
      end
      n_assert++;
      if (ra7 !== 5'd7) begin
         $display("FAIL midframe_ra got %0d want 7", ra7);
         n_fail++;
      end
      rst = 1'b0;
      dec_clr = 1'b1;
      @(posedge clk); #1;
      n_assert++;
      if ({busA.tx, busA.busy, busA.done, busA.ra} !== {3'b100, 5'd0}) begin
         $display("FAIL midframe_abort tx/busy/done/ra=%b%b%b/%0d want 100/0",
                  busA.tx, busA.busy, busA.done, busA.ra);
         n_fail++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      dec_clr = 1'b0;
      dn = 0;
      for (int i = 0; i < 20; i++) begin
         if (busA.done || busA.busy) dn++;
         @(posedge clk); #1;
      end
      n_assert++;
      if (dn != 0) begin
         $display("FAIL midframe_no_done active_cycles=%0d want 0", dn);
         n_fail++;
      end
      run_dump_a(-1, 1'b0, bc, dc, t0, t1);
      n_assert++;
      if (rxq.size() == 0 || rxq[0] !== 8'h00) begin
         $display("FAIL redump_first size=%0d want first byte 00", rxq.size());
         n_fail++;
      end
      n_assert++;
      if (stream_errs() != 0 || dc != 1) begin
         $display("FAIL redump_stream errors=%0d done=%0d want 0/1",
                  stream_errs(), dc);
         n_fail++;
      end
   endtask

   initial begin
      busA.start = 1'b0;
      busB.start = 1'b0;
      init_regs();
      test_reset();
      test_full_dump();
      test_bit_order();
      test_start_busy();
      test_live_update();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
